// File: rtl/motor_ctrl_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : motor_ctrl_ramp
//  Description : Step/dir generator for one stepper axis with a one-deep
//                command slot, trapezoidal ramping, direction setup time,
//                abort and a signed position counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module motor_ctrl_ramp #(
  parameter int DIV_W     = 13,
  parameter int STEPS_W   = 15,
  parameter int POS_W     = 19,
  parameter int DIR_SETUP = 255,
  parameter int RAMP_INC  = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               cmd_dir,
  input  logic [DIV_W-1:0]   cmd_div,
  input  logic [DIV_W-1:0]   start_div,
  input  logic               ramp_en,
  input  logic               abort,
  input  logic               pos_clear,
  output logic               dir,
  output logic               step,
  output logic               busy,
  output logic               done,
  output logic [POS_W-1:0]   position
);

  // Internal period width carries one spare bit so ramp arithmetic saturates.
  localparam int c_PW     = DIV_W + 1;
  localparam int c_WAIT_W = (DIR_SETUP > 1) ? $clog2(DIR_SETUP) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIR_WAIT = 2'd1,
    S_RUN      = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_slotFull;
  logic [STEPS_W-1:0]    r_slotSteps;
  logic                  r_slotDir;
  logic [DIV_W-1:0]      r_slotDiv;
  logic [STEPS_W-1:0]    r_remaining;
  logic [STEPS_W-1:0]    r_rampCnt;
  logic [c_PW-1:0]       r_pCur;
  logic [c_PW-1:0]       r_pTarget;
  logic [c_PW-1:0]       r_pStart;
  logic                  r_rampOn;
  logic [c_PW-1:0]       r_cnt;
  logic [c_PW-1:0]       r_hiCnt;
  logic [c_WAIT_W-1:0]   r_waitCnt;
  logic                  r_aborting;
  logic                  r_dir;
  logic                  r_step;
  logic                  r_done;
  logic [POS_W-1:0]      r_position;

  logic                  w_accept;
  logic                  w_load;
  logic                  w_issue;
  logic                  w_rampOk;
  logic [c_PW-1:0]       w_pEff;
  logic [STEPS_W-1:0]    w_remAfter;
  logic [c_PW:0]         w_pSum;
  logic [c_PW:0]         w_pFloor;
  logic [c_PW-1:0]       w_pUp;
  logic [c_PW-1:0]       w_pDown;

  assign cmd_ready = !r_slotFull;
  assign busy      = (r_state != S_IDLE);
  assign dir       = r_dir;
  assign step      = r_step;
  assign done      = r_done;
  assign position  = r_position;

  assign w_accept  = cmd_valid && !r_slotFull;
  assign w_load    = (r_state == S_IDLE) && r_slotFull && !abort;
  assign w_issue   = (r_state == S_RUN) && (r_cnt == '0) && (r_remaining != '0)
                     && !abort && !r_aborting;
  assign w_rampOk  = ramp_en && (start_div > r_slotDiv);

  // A zero period would never toggle, so it runs as a period of one.
  assign w_pEff     = (r_pCur == '0) ? c_PW'(1) : r_pCur;
  assign w_remAfter = r_remaining - STEPS_W'(1);

  // Decel step clamps at the start period, accel step clamps at the cruise period.
  assign w_pSum   = {1'b0, r_pCur} + (c_PW+1)'(RAMP_INC);
  assign w_pUp    = (w_pSum > {1'b0, r_pStart}) ? r_pStart : w_pSum[c_PW-1:0];
  assign w_pFloor = {1'b0, r_pTarget} + (c_PW+1)'(RAMP_INC);
  assign w_pDown  = ({1'b0, r_pCur} > w_pFloor) ? (r_pCur - c_PW'(RAMP_INC)) : r_pTarget;

  // Pending command slot: filled on handshake, emptied on load, flushed by abort.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_slotFull <= 1'b0;
    end else if (abort) begin
      r_slotFull <= 1'b0;
    end else if (w_accept) begin
      r_slotFull  <= 1'b1;
      r_slotSteps <= cmd_steps;
      r_slotDir   <= cmd_dir;
      r_slotDiv   <= cmd_div;
    end else if (w_load) begin
      r_slotFull <= 1'b0;
    end
  end

  // Move sequencer: load, direction setup wait, step timing and ramp profile.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_dir       <= 1'b0;
      r_step      <= 1'b0;
      r_done      <= 1'b0;
      r_aborting  <= 1'b0;
      r_cnt       <= '0;
      r_hiCnt     <= '0;
      r_waitCnt   <= '0;
      r_remaining <= '0;
      r_rampCnt   <= '0;
      r_pCur      <= '0;
      r_pTarget   <= '0;
      r_pStart    <= '0;
      r_rampOn    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // High phase lasts ceil((P+1)/2) cycles, counted independently of the period.
      if (r_step) begin
        if (r_hiCnt == '0) r_step <= 1'b0;
        else               r_hiCnt <= r_hiCnt - c_PW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            if (r_slotSteps == '0) begin
              r_done <= 1'b1;
            end else begin
              r_remaining <= r_slotSteps;
              r_rampCnt   <= '0;
              r_cnt       <= '0;
              r_aborting  <= 1'b0;
              r_pTarget   <= {1'b0, r_slotDiv};
              r_pStart    <= {1'b0, start_div};
              r_rampOn    <= w_rampOk;
              r_pCur      <= w_rampOk ? {1'b0, start_div} : {1'b0, r_slotDiv};
              if (r_slotDir != r_dir) begin
                r_dir <= r_slotDir;
                if (DIR_SETUP == 0) begin
                  r_state <= S_RUN;
                end else begin
                  r_state   <= S_DIR_WAIT;
                  r_waitCnt <= c_WAIT_W'(DIR_SETUP - 1);
                end
              end else begin
                r_state <= S_RUN;
              end
            end
          end
        end
        S_DIR_WAIT: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else if (r_waitCnt == '0) begin
            r_state <= S_RUN;
          end else begin
            r_waitCnt <= r_waitCnt - c_WAIT_W'(1);
          end
        end
        S_RUN: begin
          if (abort) r_aborting <= 1'b1;
          if (r_cnt == '0) begin
            if (w_issue) begin
              r_step      <= 1'b1;
              r_hiCnt     <= w_pEff >> 1;
              r_cnt       <= w_pEff;
              r_remaining <= w_remAfter;
              if (r_rampOn) begin
                if (w_remAfter <= r_rampCnt) begin
                  r_pCur <= w_pUp;
                end else if (r_pCur > r_pTarget) begin
                  r_pCur    <= w_pDown;
                  r_rampCnt <= r_rampCnt + STEPS_W'(1);
                end
              end
            end else begin
              // Full period of the last (or aborted) step has elapsed.
              r_state    <= S_IDLE;
              r_done     <= 1'b1;
              r_aborting <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - c_PW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Signed position tracks each issued step; a clear overrides a same-cycle step.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_position <= '0;
    end else if (pos_clear) begin
      r_position <= '0;
    end else if (w_issue) begin
      r_position <= r_dir ? (r_position + POS_W'(1)) : (r_position - POS_W'(1));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_motor_ctrl_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_motor_ctrl_ramp
//  Description : Self-checking bench for motor_ctrl_ramp: vector table,
//                randomized commands against a move-schedule model, and
//                hand-written reset / back-to-back / abort sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_motor_ctrl_ramp;

  localparam int DIV_W     = 13;
  localparam int STEPS_W   = 15;
  localparam int POS_W     = 19;
  localparam int DIR_SETUP = 255;
  localparam int RAMP_INC  = 16;

  logic               CLK = 1'b0;
  logic               reset = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [STEPS_W-1:0] cmd_steps = '0;
  logic               cmd_dir = 1'b0;
  logic [DIV_W-1:0]   cmd_div = '0;
  logic [DIV_W-1:0]   start_div = '0;
  logic               ramp_en = 1'b0;
  logic               abort = 1'b0;
  logic               pos_clear = 1'b0;
  logic               dir;
  logic               step;
  logic               busy;
  logic               done;
  logic [POS_W-1:0]   position;

  motor_ctrl_ramp #(
    .DIV_W(DIV_W), .STEPS_W(STEPS_W), .POS_W(POS_W),
    .DIR_SETUP(DIR_SETUP), .RAMP_INC(RAMP_INC)
  ) dut (
    .CLK(CLK), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_div(cmd_div),
    .start_div(start_div), .ramp_en(ramp_en), .abort(abort),
    .pos_clear(pos_clear), .dir(dir), .step(step), .busy(busy),
    .done(done), .position(position)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- move-schedule reference model ----------------
  typedef struct { int at; int hi; bit d; } rise_t;
  rise_t riseQ[$];
  int    doneQ[$];
  int    riseLog[$];
  int    idleFrom = 0;
  int    slotFree = 0;
  bit    curDir   = 1'b0;
  int    expPos   = 0;
  int    pulseCnt = 0;
  bit    monOn    = 1'b0;

  // Timeline of one command accepted at edge a: load edge, rise edges,
  // high widths and done edge, straight from the move rules.
  task automatic schedule(input int a, input int steps, input bit d,
                          input int div, input int start, input bit ramp);
    int l, t, p, pe, rc, rem;
    bit ramping;
    l = (a + 1 > idleFrom) ? a + 1 : idleFrom;
    slotFree = l;
    if (steps == 0) begin
      doneQ.push_back(l);
      idleFrom = l + 1;
      return;
    end
    t = (d != curDir) ? l + DIR_SETUP + 1 : l + 1;
    curDir = d;
    ramping = ramp && (start > div);
    p = ramping ? start : div;
    rc = 0;
    for (int k = 0; k < steps; k++) begin
      pe = (p == 0) ? 1 : p;
      riseQ.push_back('{at: t, hi: (pe + 2) / 2, d: d});
      t += pe + 1;
      rem = steps - 1 - k;
      if (ramping) begin
        if (rem <= rc) p = (p + RAMP_INC > start) ? start : p + RAMP_INC;
        else if (p > div) begin
          p = (p - RAMP_INC < div) ? div : p - RAMP_INC;
          rc++;
        end
      end
    end
    doneQ.push_back(t);
    idleFrom = t + 1;
    expPos += d ? steps : -steps;
  endtask

  // Output monitor: compares observed rises, high widths and done pulses to the model.
  bit prevStep = 1'b0;
  bit hiTracked = 1'b0;
  int hiRun = 0;
  int hiExp = 0;
  always @(posedge CLK) begin
    #1;
    if (!monOn) begin
      hiTracked = 1'b0;
    end else begin
      if (step && !prevStep) begin
        rise_t e;
        if (riseQ.size() != 0) e = riseQ.pop_front();
        else                   e = '{at: -1, hi: 0, d: 1'b0};
        riseLog.push_back(cyc);
        pulseCnt++;
        chk("rise_edge", cyc, e.at);
        chk("dir_at_rise", int'(dir), int'(e.d));
        hiExp = e.hi;
        hiRun = 0;
        hiTracked = 1'b1;
      end
      if (step) hiRun++;
      if (!step && prevStep && hiTracked) begin
        chk("high_len", hiRun, hiExp);
        hiTracked = 1'b0;
      end
      if (done) begin
        int de;
        if (doneQ.size() != 0) de = doneQ.pop_front();
        else                   de = -1;
        chk("done_edge", cyc, de);
      end
    end
    prevStep = step;
  end

  task automatic sendCmd(input int steps, input bit d, input int div,
                         input int start, input bit ramp);
    int guard = 0;
    int a;
    while (cyc < slotFree && guard < 20000) begin
      tick();
      guard++;
    end
    chk("cmd_ready_free", int'(cmd_ready), 1);
    cmd_steps = STEPS_W'(steps);
    cmd_dir   = d;
    cmd_div   = DIV_W'(div);
    start_div = DIV_W'(start);
    ramp_en   = ramp;
    cmd_valid = 1'b1;
    tick();
    a = cyc;
    cmd_valid = 1'b0;
    chk("cmd_ready_full", int'(cmd_ready), 0);
    schedule(a, steps, d, div, start, ramp);
  endtask

  task automatic waitIdle();
    int guard = 0;
    while ((riseQ.size() != 0 || doneQ.size() != 0 || cyc < idleFrom) && guard < 30000) begin
      tick();
      guard++;
    end
    chk("idle_pending", riseQ.size() + doneQ.size(), 0);
    chk("busy_idle", int'(busy), 0);
    chk("position", int'($signed(position)), expPos);
  endtask

  task automatic syncAfterReset();
    riseQ.delete();
    doneQ.delete();
    curDir   = 1'b0;
    expPos   = 0;
    idleFrom = cyc + 1;
    slotFree = cyc;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected self-termination");
    $fatal(1);
  end

  typedef struct {
    int steps; bit d; int div; int start; bit ramp;
    int expPos; int expPulses; bit chkPer;
  } vec_t;

  initial begin
    vec_t vt[6];
    int   perExp[9];
    int   base, r0, pos0, fallEdge, doneEdge, rises, sgn;
    bit   rd, pv;

    perExp = '{101, 85, 69, 53, 53, 53, 53, 69, 85};
    vt[0] = '{4,  1'b0, 9,  0,   1'b0, -4, 4,  1'b0};
    vt[1] = '{3,  1'b1, 5,  0,   1'b0, -1, 3,  1'b0};
    vt[2] = '{10, 1'b1, 52, 100, 1'b1, 9,  10, 1'b1};
    vt[3] = '{0,  1'b0, 7,  0,   1'b0, 9,  0,  1'b0};
    vt[4] = '{3,  1'b1, 0,  0,   1'b0, 12, 3,  1'b0};
    vt[5] = '{2,  1'b1, 20, 10,  1'b1, 14, 2,  1'b0};

    // Reset state
    tick(); tick();
    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_position", int'(position), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    reset = 1'b1;
    syncAfterReset();
    monOn = 1'b1;

    // Vector table
    for (int i = 0; i < 6; i++) begin
      pulseCnt = 0;
      base = riseLog.size();
      sendCmd(vt[i].steps, vt[i].d, vt[i].div, vt[i].start, vt[i].ramp);
      waitIdle();
      chk("vec_position", int'($signed(position)), vt[i].expPos);
      chk("vec_pulses", pulseCnt, vt[i].expPulses);
      if (vt[i].chkPer) begin
        for (int k = 1; k < 10; k++)
          chk("ramp_period", riseLog[base + k] - riseLog[base + k - 1], perExp[k - 1]);
      end
    end

    // Back-to-back commands; a third is held off while the slot is full
    sendCmd(3, 1'b1, 4, 0, 1'b0);
    sendCmd(2, 1'b1, 6, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ready_held_off", int'(cmd_ready), 0);
    end
    sendCmd(1, 1'b1, 3, 0, 1'b0);
    waitIdle();

    // Randomized commands
    rd = curDir;
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 3) == 0) rd = !rd;
      sendCmd($urandom_range(0, 5), rd, $urandom_range(0, 10),
              $urandom_range(0, 40), 1'($urandom_range(0, 1)));
      if ((i % 4) == 3) waitIdle();
    end
    waitIdle();

    // Position clear in idle
    pos_clear = 1'b1;
    tick();
    pos_clear = 1'b0;
    chk("pos_clear", int'(position), 0);
    expPos = 0;

    // Abort during the high phase with a command pending
    monOn = 1'b0;
    pos0 = expPos;
    sgn = curDir ? 1 : -1;
    sendCmd(5, curDir, 19, 0, 1'b0);
    r0 = riseQ[0].at;
    sendCmd(4, curDir, 3, 0, 1'b0);
    while (cyc < r0 + 2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_flush_ready", int'(cmd_ready), 1);
    fallEdge = -1;
    doneEdge = -1;
    rises = 0;
    pv = step;
    while (cyc < r0 + 60) begin
      tick();
      if (!step && fallEdge < 0) fallEdge = cyc;
      if (step && !pv) rises++;
      if (done && doneEdge < 0) doneEdge = cyc;
      pv = step;
    end
    chk("abort_fall_edge", fallEdge - r0, 10);
    chk("abort_done_edge", doneEdge - r0, 20);
    chk("abort_no_steps", rises, 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_position", int'($signed(position)), pos0 + sgn);
    riseQ.delete();
    doneQ.delete();
    expPos = pos0 + sgn;
    idleFrom = cyc;
    slotFree = cyc;

    // Reset in the middle of a move
    sendCmd(20, curDir, 9, 0, 1'b0);
    for (int k = 0; k < 30; k++) tick();
    reset = 1'b0;
    tick();
    chk("midrst_step", int'(step), 0);
    chk("midrst_position", int'(position), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    tick();
    reset = 1'b1;
    syncAfterReset();
    rises = 0;
    pv = step;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (step && !pv) rises++;
      pv = step;
    end
    chk("midrst_no_steps", rises, 0);
    prevStep = step;
    monOn = 1'b1;
    sendCmd(2, 1'b0, 3, 0, 1'b0);
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
